// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  // Bits needed to index n items, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] f,
  output logic       c4,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    f  = p ^ {c3, c2, c1, c0};
  end

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder sequencing one shared 4-bit CLA slice LSB first.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.
module cla_seq_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = clog2(NSLICE);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_f;
  logic               slice_c4;

  assign slice_a = x_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b = y_q[SLICE_W*idx_q +: SLICE_W];

`ifdef CLA_SEQ_OVF_EN
  logic slice_c3;
  logic ovf_q, ovf_d;

  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .c0 (carry_q),
    .f  (slice_f),
    .c4 (slice_c4),
    .c3 (slice_c3)
  );
`else
  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .c0 (carry_q),
    .f  (slice_f),
    .c4 (slice_c4),
    .c3 ()
  );
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = slice_f;
        carry_d = slice_c4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          cout_d  = slice_c4;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = slice_c3 ^ slice_c4;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed self-checking bench for cla_seq_ctrl (WIDTH=16).
module tb_cla_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int total;
  int bad;
  int lat;

  cla_seq_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, accept it, and count edges until out_valid.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] ya, input logic ca,
                       output int latency);
    x        = xa;
    y        = ya;
    cin      = ca;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x        = 16'hDEAD;
    y        = 16'hBEEF;
    cin      = 1'b1;
    latency  = 0;
    while (!out_valid && latency < 20) begin
      check("in_ready_run", {31'b0, in_ready}, 32'd0);
      tick();
      latency++;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    cin       = 1'b0;

    #12;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum",       {16'b0, sum},       32'd0);
    check("rst_cout",      {31'b0, cout},      32'd0);
`ifdef CLA_SEQ_OVF_EN
    check("rst_ovf",       {31'b0, ovf},       32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 0x1234 + 0x4321
    do_op(16'h1234, 16'h4321, 1'b0, lat);
    check("t1_latency",  lat, 32'd4);
    check("t1_sum",      {16'b0, sum},  32'h5555);
    check("t1_cout",     {31'b0, cout}, 32'd0);
    check("t1_in_ready_done", {31'b0, in_ready}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
    check("t1_ovf",      {31'b0, ovf},  32'd0);
`endif
    tick();
    check("t1_back_idle", {31'b0, in_ready},  32'd1);
    check("t1_ov_low",    {31'b0, out_valid}, 32'd0);

    // Full carry chain
    do_op(16'hFFFF, 16'h0001, 1'b0, lat);
    check("t2_latency", lat, 32'd4);
    check("t2_sum",     {16'b0, sum},  32'h0000);
    check("t2_cout",    {31'b0, cout}, 32'd1);
    tick();
    do_op(16'hFFFF, 16'h0000, 1'b1, lat);
    check("t3_sum",     {16'b0, sum},  32'h0000);
    check("t3_cout",    {31'b0, cout}, 32'd1);
    tick();

    // Output stall with ignored in_valid pulses
    out_ready = 1'b0;
    do_op(16'h00F0, 16'h0010, 1'b0, lat);
    check("t4_latency", lat, 32'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      x        = 16'h1111;
      y        = 16'h2222;
      tick();
      check("t4_stall_valid", {31'b0, out_valid}, 32'd1);
      check("t4_stall_sum",   {16'b0, sum},       32'h0100);
      check("t4_stall_cout",  {31'b0, cout},      32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t4_back_idle", {31'b0, in_ready},  32'd1);
    check("t4_ov_low",    {31'b0, out_valid}, 32'd0);
    check("t4_sum_kept",  {16'b0, sum},       32'h0100);

    // Reset during the second RUN cycle
    x        = 16'hAAAA;
    y        = 16'h5555;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("t5_rst_sum",       {16'b0, sum},       32'd0);
    check("t5_rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("t5_rst_cout",      {31'b0, cout},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(16'h0001, 16'h0001, 1'b0, lat);
    check("t5_latency", lat, 32'd4);
    check("t5_sum",     {16'b0, sum},  32'h0002);
    check("t5_cout",    {31'b0, cout}, 32'd0);
    tick();

`ifdef CLA_SEQ_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, lat);
    check("ovf1_sum",  {16'b0, sum},  32'h8000);
    check("ovf1_cout", {31'b0, cout}, 32'd0);
    check("ovf1_ovf",  {31'b0, ovf},  32'd1);
    tick();
    do_op(16'h8000, 16'h8000, 1'b0, lat);
    check("ovf2_sum",  {16'b0, sum},  32'h0000);
    check("ovf2_cout", {31'b0, cout}, 32'd1);
    check("ovf2_ovf",  {31'b0, ovf},  32'd1);
    tick();
    do_op(16'h1234, 16'h4321, 1'b0, lat);
    check("ovf3_ovf",  {31'b0, ovf},  32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
